gpio_ctrl_fsm: RTL and testbench



---
 rtl/gpio_ctrl_fsm.sv | 234 +++++++++++++++++++++++
 tb/tb_gpio_ctrl_fsm.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_ctrl_fsm.sv
// gpio_ctrl_fsm: decodes strobed GPIO commands into MCU sequencing and
// convolver control, and returns MCU result data through the GPIO status word.
module gpio_ctrl_fsm #(
    parameter int unsigned GPIO_D      = 32,
    parameter int unsigned NB_ADDRESS  = 4,
    parameter int unsigned BITS_IMAGEN = 8,
    parameter int unsigned BITS_DATA   = 13,
    parameter int unsigned LATENCY     = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [GPIO_D-1:0]      i_gpio,
    input  logic [BITS_DATA-1:0]   i_Data,
    output logic [GPIO_D-1:0]      o_gpio,
    output logic [BITS_IMAGEN-1:0] o_Data,
    output logic [NB_ADDRESS-1:0]  o_RAddr,
    output logic [NB_ADDRESS-1:0]  o_WAddr,
    output logic                   o_sop,
    output logic                   o_eop,
    output logic                   o_chblk,
    output logic                   o_valid,
    output logic                   o_ki
);

    localparam int unsigned OPC_W = 3;
    localparam int unsigned PAD_W = GPIO_D - 3 - BITS_DATA;

    localparam logic [OPC_W-1:0] OP_SOFT_RST    = 3'b001;
    localparam logic [OPC_W-1:0] OP_LOAD_KERNEL = 3'b010;
    localparam logic [OPC_W-1:0] OP_LOAD_IMAGE  = 3'b011;
    localparam logic [OPC_W-1:0] OP_START       = 3'b100;
    localparam logic [OPC_W-1:0] OP_NEXT_DATA   = 3'b101;
    localparam logic [OPC_W-1:0] OP_CHBLK       = 3'b110;

    localparam logic [NB_ADDRESS-1:0]  ADDR_MAX  = '1;
    localparam logic [NB_ADDRESS-1:0]  ADDR_TERM = ADDR_MAX - NB_ADDRESS'(2);
    localparam logic [NB_ADDRESS-1:0]  ADDR_LAT  = NB_ADDRESS'(LATENCY);
    localparam logic [BITS_IMAGEN-1:0] DATA_RST  = BITS_IMAGEN'(8'h55);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t r_state, w_state_nxt;

    logic                   r_stb_s1, r_stb_s2, r_stb_s3;
    logic [OPC_W-1:0]       r_op1, r_op2;
    logic [BITS_IMAGEN-1:0] r_pay1, r_pay2;

    logic                   r_sop, r_eop, r_chblk, r_valid, r_ki, r_ack;
    logic                   r_busy, r_done, r_ld_pend;
    logic [BITS_IMAGEN-1:0] r_data;
    logic [NB_ADDRESS-1:0]  r_raddr, r_waddr;
    logic [BITS_DATA-1:0]   r_idata;

    logic                   w_sop_nxt, w_eop_nxt, w_chblk_nxt, w_valid_nxt, w_ki_nxt, w_ack_nxt;
    logic                   w_ld_pend_nxt;
    logic [BITS_IMAGEN-1:0] w_data_nxt;
    logic [NB_ADDRESS-1:0]  w_raddr_nxt, w_waddr_nxt;
    logic [BITS_DATA-1:0]   w_idata_nxt;
    logic                   w_stb_edge;
    logic                   w_unused_gpio;

    assign w_stb_edge    = r_stb_s2 & ~r_stb_s3;
    assign w_unused_gpio = ^i_gpio[GPIO_D-5:BITS_IMAGEN];

    // Strobe synchroniser + edge flop; opcode/payload travel alongside the strobe
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stb_s1 <= 1'b0;
            r_stb_s2 <= 1'b0;
            r_stb_s3 <= 1'b0;
            r_op1    <= '0;
            r_op2    <= '0;
            r_pay1   <= '0;
            r_pay2   <= '0;
        end else begin
            r_stb_s1 <= i_gpio[GPIO_D-4];
            r_stb_s2 <= r_stb_s1;
            r_stb_s3 <= r_stb_s2;
            r_op1    <= i_gpio[GPIO_D-1 -: OPC_W];
            r_op2    <= r_op1;
            r_pay1   <= i_gpio[BITS_IMAGEN-1:0];
            r_pay2   <= r_pay1;
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next state and next values of every registered output
    always_comb begin
        w_state_nxt   = r_state;
        w_sop_nxt     = r_sop;
        w_eop_nxt     = r_eop;
        w_chblk_nxt   = 1'b0;
        w_valid_nxt   = 1'b0;
        w_ki_nxt      = r_ki;
        w_data_nxt    = r_data;
        w_raddr_nxt   = r_raddr;
        w_waddr_nxt   = r_waddr;
        w_ack_nxt     = r_ack;
        w_ld_pend_nxt = 1'b0;
        w_idata_nxt   = i_Data;

        // Cycle after an image load: advance the write pointer, close the load
        if (r_ld_pend) begin
            w_waddr_nxt = r_waddr + NB_ADDRESS'(1);
            w_eop_nxt   = 1'b1;
        end

        if (r_state == ST_RUN) begin
            if (r_waddr == ADDR_TERM) begin
                w_sop_nxt   = 1'b0;
                w_eop_nxt   = 1'b1;
                w_raddr_nxt = '0;
                w_waddr_nxt = '0;
                w_state_nxt = ST_DONE;
            end else begin
                w_valid_nxt = 1'b1;
                w_raddr_nxt = (r_raddr == ADDR_MAX) ? r_raddr : r_raddr + NB_ADDRESS'(1);
                w_waddr_nxt = (r_raddr < ADDR_LAT) ? '0 : r_waddr + NB_ADDRESS'(1);
            end
        end

        if (w_stb_edge) begin
            if (r_op2 == OP_SOFT_RST) begin
                w_sop_nxt     = 1'b0;
                w_eop_nxt     = 1'b1;
                w_chblk_nxt   = 1'b0;
                w_valid_nxt   = 1'b0;
                w_ki_nxt      = 1'b1;
                w_data_nxt    = DATA_RST;
                w_raddr_nxt   = '0;
                w_waddr_nxt   = '0;
                w_idata_nxt   = '0;
                w_ld_pend_nxt = 1'b0;
                w_ack_nxt     = ~r_ack;
                w_state_nxt   = ST_IDLE;
            end else if (r_state != ST_RUN) begin
                case (r_op2)
                    OP_LOAD_KERNEL: begin
                        w_ki_nxt    = 1'b1;
                        w_data_nxt  = r_pay2;
                        w_valid_nxt = 1'b1;
                        w_ack_nxt   = ~r_ack;
                        w_state_nxt = ST_IDLE;
                    end
                    OP_LOAD_IMAGE: begin
                        w_ki_nxt      = 1'b0;
                        w_data_nxt    = r_pay2;
                        w_sop_nxt     = 1'b0;
                        w_eop_nxt     = 1'b0;
                        w_ld_pend_nxt = 1'b1;
                        w_ack_nxt     = ~r_ack;
                        w_state_nxt   = ST_IDLE;
                    end
                    OP_START: begin
                        w_sop_nxt   = 1'b1;
                        w_eop_nxt   = 1'b0;
                        w_ki_nxt    = 1'b0;
                        w_raddr_nxt = '0;
                        w_waddr_nxt = '0;
                        w_valid_nxt = 1'b0;
                        w_ack_nxt   = ~r_ack;
                        w_state_nxt = ST_RUN;
                    end
                    OP_NEXT_DATA: begin
                        if (r_state == ST_DONE) begin
                            w_raddr_nxt = r_raddr + NB_ADDRESS'(1);
                            w_ack_nxt   = ~r_ack;
                        end
                    end
                    OP_CHBLK: begin
                        w_chblk_nxt = 1'b1;
                        w_ack_nxt   = ~r_ack;
                    end
                    default: begin
                        w_ack_nxt = ~r_ack;
                    end
                endcase
            end
        end
    end

    // Output and status registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sop     <= 1'b0;
            r_eop     <= 1'b1;
            r_chblk   <= 1'b0;
            r_valid   <= 1'b0;
            r_ki      <= 1'b1;
            r_data    <= DATA_RST;
            r_raddr   <= '0;
            r_waddr   <= '0;
            r_ack     <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_ld_pend <= 1'b0;
            r_idata   <= '0;
        end else begin
            r_sop     <= w_sop_nxt;
            r_eop     <= w_eop_nxt;
            r_chblk   <= w_chblk_nxt;
            r_valid   <= w_valid_nxt;
            r_ki      <= w_ki_nxt;
            r_data    <= w_data_nxt;
            r_raddr   <= w_raddr_nxt;
            r_waddr   <= w_waddr_nxt;
            r_ack     <= w_ack_nxt;
            r_busy    <= (w_state_nxt == ST_RUN);
            r_done    <= (w_state_nxt == ST_DONE);
            r_ld_pend <= w_ld_pend_nxt;
            r_idata   <= w_idata_nxt;
        end
    end

    assign o_gpio  = {r_busy, r_done, r_ack, {PAD_W{1'b0}}, r_idata};
    assign o_Data  = r_data;
    assign o_RAddr = r_raddr;
    assign o_WAddr = r_waddr;
    assign o_sop   = r_sop;
    assign o_eop   = r_eop;
    assign o_chblk = r_chblk;
    assign o_valid = r_valid;
    assign o_ki    = r_ki;

endmodule

// File: tb/tb_gpio_ctrl_fsm.sv
// Testbench for gpio_ctrl_fsm: directed command sequence with random payloads,
// random don't-care GPIO bits and random MCU data, checked against timing rules.
module tb_gpio_ctrl_fsm;

    localparam int unsigned GPIO_D      = 32;
    localparam int unsigned NB_ADDRESS  = 4;
    localparam int unsigned BITS_IMAGEN = 8;
    localparam int unsigned BITS_DATA   = 13;
    localparam int unsigned LATENCY     = 5;
    localparam int          RUN_LEN     = 19;

    logic                   clk;
    logic                   rst;
    logic [GPIO_D-1:0]      i_gpio;
    logic [BITS_DATA-1:0]   i_Data;
    logic [GPIO_D-1:0]      o_gpio;
    logic [BITS_IMAGEN-1:0] o_Data;
    logic [NB_ADDRESS-1:0]  o_RAddr, o_WAddr;
    logic                   o_sop, o_eop, o_chblk, o_valid, o_ki;

    int total = 0;
    int bad   = 0;

    logic                 m_ack;
    logic                 m_ki;
    logic [7:0]           m_data;
    logic [BITS_DATA-1:0] last_idata;
    logic [2:0]           opt [5] = '{3'd2, 3'd6, 3'd0, 3'd7, 3'd5};

    gpio_ctrl_fsm #(
        .GPIO_D(GPIO_D), .NB_ADDRESS(NB_ADDRESS), .BITS_IMAGEN(BITS_IMAGEN),
        .BITS_DATA(BITS_DATA), .LATENCY(LATENCY)
    ) dut (
        .clk(clk), .rst(rst), .i_gpio(i_gpio), .i_Data(i_Data),
        .o_gpio(o_gpio), .o_Data(o_Data), .o_RAddr(o_RAddr), .o_WAddr(o_WAddr),
        .o_sop(o_sop), .o_eop(o_eop), .o_chblk(o_chblk), .o_valid(o_valid), .o_ki(o_ki)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            last_idata = i_Data;
            i_Data     = BITS_DATA'($urandom);
        end
    endtask

    task automatic strobe_on(input logic [2:0] op, input logic [7:0] pay);
        logic [31:0] w;
        w        = $urandom;
        w[31:29] = op;
        w[28]    = 1'b1;
        w[7:0]   = pay;
        i_gpio   = w;
    endtask

    task automatic strobe_off();
        i_gpio[28] = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_sop"},   32'(o_sop),      32'd0);
        chk({tag, "_eop"},   32'(o_eop),      32'd1);
        chk({tag, "_chblk"}, 32'(o_chblk),    32'd0);
        chk({tag, "_valid"}, 32'(o_valid),    32'd0);
        chk({tag, "_ki"},    32'(o_ki),       32'd1);
        chk({tag, "_data"},  32'(o_Data),     32'h55);
        chk({tag, "_raddr"}, 32'(o_RAddr),    32'd0);
        chk({tag, "_waddr"}, 32'(o_WAddr),    32'd0);
        chk({tag, "_busy"},  32'(o_gpio[31]), 32'd0);
        chk({tag, "_done"},  32'(o_gpio[30]), 32'd0);
    endtask

    // Called right after the START edge T; checks T+1 .. T+19
    task automatic run_check(input bit inject);
        int er, ew;
        for (int n = 1; n <= RUN_LEN; n++) begin
            tick(1);
            if (n < RUN_LEN) begin
                er = (n > 15) ? 15 : n;
                ew = (n <= int'(LATENCY)) ? 0 : n - int'(LATENCY);
                chk("run_sop",   32'(o_sop),      32'd1);
                chk("run_eop",   32'(o_eop),      32'd0);
                chk("run_valid", 32'(o_valid),    32'd1);
                chk("run_raddr", 32'(o_RAddr),    32'(er));
                chk("run_waddr", 32'(o_WAddr),    32'(ew));
                chk("run_busy",  32'(o_gpio[31]), 32'd1);
                chk("run_ki",    32'(o_ki),       32'd0);
                chk("run_data",  32'(o_Data),     32'(m_data));
                chk("run_ack",   32'(o_gpio[29]), 32'(m_ack));
            end else begin
                chk("end_sop",   32'(o_sop),      32'd0);
                chk("end_eop",   32'(o_eop),      32'd1);
                chk("end_valid", 32'(o_valid),    32'd0);
                chk("end_raddr", 32'(o_RAddr),    32'd0);
                chk("end_waddr", 32'(o_WAddr),    32'd0);
                chk("end_done",  32'(o_gpio[30]), 32'd1);
                chk("end_busy",  32'(o_gpio[31]), 32'd0);
                chk("end_ack",   32'(o_gpio[29]), 32'(m_ack));
            end
            if (inject && n == 4)  strobe_on(3'b010, 8'($urandom));
            if (inject && n == 10) strobe_off();
        end
    endtask

    task automatic do_start();
        strobe_on(3'b100, 8'($urandom));
        tick(3);
        m_ack = ~m_ack;
        m_ki  = 1'b0;
        chk("start_sop",   32'(o_sop),      32'd1);
        chk("start_eop",   32'(o_eop),      32'd0);
        chk("start_valid", 32'(o_valid),    32'd0);
        chk("start_raddr", 32'(o_RAddr),    32'd0);
        chk("start_waddr", 32'(o_WAddr),    32'd0);
        chk("start_busy",  32'(o_gpio[31]), 32'd1);
        chk("start_ack",   32'(o_gpio[29]), 32'(m_ack));
        strobe_off();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [2:0] op;
        logic [7:0] pay;
        int         pulses;

        rst        = 1'b0;
        i_gpio     = '0;
        i_Data     = '0;
        last_idata = '0;
        m_ack      = 1'b0;
        m_ki       = 1'b1;
        m_data     = 8'h55;

        // Reset applied before any clock edge
        #2 rst = 1'b1;
        #1;
        chk_reset_vals("rst");
        chk("rst_gpio", o_gpio, 32'd0);
        tick(2);
        rst = 1'b0;
        tick(2);

        // LOAD_KERNEL 0x07, then strobe held high
        strobe_on(3'b010, 8'h07);
        tick(2);
        chk("lk_early_valid", 32'(o_valid), 32'd0);
        tick(1);
        m_ack  = ~m_ack;
        m_data = 8'h07;
        chk("lk_valid", 32'(o_valid),    32'd1);
        chk("lk_ki",    32'(o_ki),       32'd1);
        chk("lk_data",  32'(o_Data),     32'h07);
        chk("lk_ack",   32'(o_gpio[29]), 32'(m_ack));
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            pulses += int'(o_valid);
        end
        chk("lk_hold_pulses", 32'(pulses),     32'd0);
        chk("lk_hold_ack",    32'(o_gpio[29]), 32'(m_ack));
        strobe_off();
        tick(3);

        // Random IDLE commands: LOAD_KERNEL, CHBLK, NOP, 111, NEXT_DATA (ignored)
        for (int r = 0; r < 8; r++) begin
            op  = opt[$urandom_range(0, 4)];
            pay = 8'($urandom);
            strobe_on(op, pay);
            tick(3);
            if (op != 3'd5) m_ack = ~m_ack;
            if (op == 3'd2) begin
                m_ki   = 1'b1;
                m_data = pay;
            end
            chk("idle_ack",   32'(o_gpio[29]), 32'(m_ack));
            chk("idle_valid", 32'(o_valid),    32'(op == 3'd2));
            chk("idle_chblk", 32'(o_chblk),    32'(op == 3'd6));
            chk("idle_ki",    32'(o_ki),       32'(m_ki));
            chk("idle_data",  32'(o_Data),     32'(m_data));
            chk("idle_raddr", 32'(o_RAddr),    32'd0);
            chk("idle_waddr", 32'(o_WAddr),    32'd0);
            tick(1);
            chk("idle_valid_off", 32'(o_valid), 32'd0);
            chk("idle_chblk_off", 32'(o_chblk), 32'd0);
            strobe_off();
            tick($urandom_range(2, 4));
        end

        // LOAD_IMAGE x16 with payload = index; write address walks and wraps
        for (int i = 0; i < 16; i++) begin
            strobe_on(3'b011, 8'(i));
            tick(2);
            chk("li_pre_eop", 32'(o_eop), 32'd1);
            tick(1);
            m_ack  = ~m_ack;
            m_ki   = 1'b0;
            m_data = 8'(i);
            chk("li_sop",   32'(o_sop),      32'd0);
            chk("li_eop",   32'(o_eop),      32'd0);
            chk("li_waddr", 32'(o_WAddr),    32'(i));
            chk("li_ki",    32'(o_ki),       32'd0);
            chk("li_data",  32'(o_Data),     32'(i));
            chk("li_ack",   32'(o_gpio[29]), 32'(m_ack));
            tick(1);
            chk("li_post_eop",   32'(o_eop),   32'd1);
            chk("li_post_waddr", 32'(o_WAddr), 32'((i + 1) % 16));
            strobe_off();
            tick(2);
        end

        // Full RUN with an ignored LOAD_KERNEL mid-run
        do_start();
        run_check(1'b1);
        tick(2);

        // DONE: NEXT_DATA x3
        for (int j = 1; j <= 3; j++) begin
            strobe_on(3'b101, 8'($urandom));
            tick(3);
            m_ack = ~m_ack;
            chk("nd_raddr", 32'(o_RAddr),    32'(j));
            chk("nd_done",  32'(o_gpio[30]), 32'd1);
            chk("nd_eop",   32'(o_eop),      32'd1);
            chk("nd_ack",   32'(o_gpio[29]), 32'(m_ack));
            strobe_off();
            tick(2);
        end

        // Status data lags i_Data by one clock
        for (int j = 0; j < 6; j++) begin
            tick(1);
            chk("gpio_lag", 32'(o_gpio[12:0]), 32'(last_idata));
            chk("gpio_pad", 32'(o_gpio[28:13]), 32'd0);
        end

        // SOFT_RST executed at T+10 of a RUN
        do_start();
        for (int n = 1; n <= 7; n++) begin
            tick(1);
            chk("sr_run_waddr", 32'(o_WAddr), 32'((n <= int'(LATENCY)) ? 0 : n - int'(LATENCY)));
        end
        strobe_on(3'b001, 8'($urandom));
        tick(2);
        chk("sr_pre_busy", 32'(o_gpio[31]), 32'd1);
        tick(1);
        m_ack  = ~m_ack;
        m_ki   = 1'b1;
        m_data = 8'h55;
        chk_reset_vals("sr");
        chk("sr_ack",  32'(o_gpio[29]),   32'(m_ack));
        chk("sr_gpio", 32'(o_gpio[12:0]), 32'd0);
        strobe_off();
        tick(3);

        // Following START runs the full length
        do_start();
        run_check(1'b0);
        tick(2);

        // LOAD_KERNEL from DONE returns to IDLE
        pay = 8'($urandom);
        strobe_on(3'b010, pay);
        tick(3);
        m_ack  = ~m_ack;
        m_ki   = 1'b1;
        m_data = pay;
        chk("dlk_busy",  32'(o_gpio[31]), 32'd0);
        chk("dlk_done",  32'(o_gpio[30]), 32'd0);
        chk("dlk_valid", 32'(o_valid),    32'd1);
        chk("dlk_data",  32'(o_Data),     32'(pay));
        chk("dlk_ack",   32'(o_gpio[29]), 32'(m_ack));
        strobe_off();
        tick(3);

        // Asynchronous reset in the middle of a RUN
        do_start();
        tick(5);
        #2 rst = 1'b1;
        #1;
        m_ack  = 1'b0;
        m_ki   = 1'b1;
        m_data = 8'h55;
        chk_reset_vals("arst");
        chk("arst_gpio", o_gpio, 32'd0);
        tick(1);
        rst = 1'b0;
        tick(2);
        chk_reset_vals("arst_idle");
        chk("arst_ack", 32'(o_gpio[29]), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
